// File: rtl/qpsk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qpsk_pkg : shared widths, FSM state types and bit-mapping values |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package qpsk_pkg;

  localparam int SPS_DEFAULT = 16;
  localparam int SAMPLE_W    = 8;
  localparam int PROD_W      = 16;
  localparam int SOFT_W      = 12;

  // A non-negative correlation decides 1, a negative one decides 0.
  localparam logic BIT_POS = 1'b1;
  localparam logic BIT_NEG = 1'b0;

  typedef enum logic {
    SEEK,
    TRACK
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/qpsk_correlator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qpsk_correlator : signed sample x carrier multiply-accumulate    |
// | with load / accumulate / clear controls and dump-sum top bits.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module qpsk_correlator
  import qpsk_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int TOP_W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [SAMPLE_W-1:0] carrier,
  input  logic                       load,
  input  logic                       acc_en,
  input  logic                       clear,
  output logic        [TOP_W-1:0]    dump_top
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;

  assign prod     = sample * carrier;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // The dumped value includes the current sample, so expose acc+prod.
  assign sum      = acc + prod_ext;
  assign dump_top = sum[ACC_W-1 -: TOP_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= prod_ext;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qpsk_demod.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qpsk_demod : coherent QPSK integrate-and-dump demodulator with   |
// | dibit re-serializer. QPSK_DEMOD_SOFT_EN adds soft_i/soft_q.      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter int SPS   = SPS_DEFAULT,
  parameter int ACC_W = 16 + $clog2(SPS)
) (
  input  logic                       clk_1,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] qpsk_in,
  input  logic signed [SAMPLE_W-1:0] sine,
  input  logic signed [SAMPLE_W-1:0] cos,
  input  logic                       sample_en,
  input  logic                       sym_start,
  output logic        [1:0]          data,
  output logic                       data_valid,
  output logic                       seq_out,
  output logic                       seq_valid
`ifdef QPSK_DEMOD_SOFT_EN
  ,
  output logic signed [SOFT_W-1:0]   soft_i,
  output logic signed [SOFT_W-1:0]   soft_q
`endif
);

  localparam int CNT_W = $clog2(SPS);
`ifdef QPSK_DEMOD_SOFT_EN
  localparam int TOP_W = SOFT_W;
`else
  localparam int TOP_W = 1;
`endif

  rx_state_t        rx_state, rx_next;
  ser_state_t       ser_state, ser_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load, acc_en, clear, dump;
  logic [TOP_W-1:0] top_i, top_q;

  qpsk_correlator #(.ACC_W(ACC_W), .TOP_W(TOP_W)) u_corr_i (
    .clk      (clk_1),
    .rst      (rst),
    .sample   (qpsk_in),
    .carrier  (cos),
    .load     (load),
    .acc_en   (acc_en),
    .clear    (clear),
    .dump_top (top_i)
  );

  qpsk_correlator #(.ACC_W(ACC_W), .TOP_W(TOP_W)) u_corr_q (
    .clk      (clk_1),
    .rst      (rst),
    .sample   (qpsk_in),
    .carrier  (sine),
    .load     (load),
    .acc_en   (acc_en),
    .clear    (clear),
    .dump_top (top_q)
  );

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      rx_state <= SEEK;
      cnt      <= '0;
    end else begin
      rx_state <= rx_next;
      cnt      <= cnt_next;
    end
  end

  // sym_start takes priority over a dump so a late resync discards the symbol.
  always_comb begin
    rx_next  = rx_state;
    cnt_next = cnt;
    load     = 1'b0;
    acc_en   = 1'b0;
    clear    = 1'b0;
    dump     = 1'b0;
    case (rx_state)
      SEEK: begin
        if (sample_en && sym_start) begin
          load     = 1'b1;
          cnt_next = CNT_W'(1);
          rx_next  = TRACK;
        end
      end
      TRACK: begin
        if (sample_en) begin
          if (sym_start) begin
            load     = 1'b1;
            cnt_next = CNT_W'(1);
          end else if (cnt == CNT_W'(SPS-1)) begin
            dump     = 1'b1;
            clear    = 1'b1;
            cnt_next = '0;
          end else begin
            acc_en   = 1'b1;
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      data       <= 2'b00;
      data_valid <= 1'b0;
    end else begin
      data_valid <= dump;
      if (dump) begin
        data <= {top_q[TOP_W-1] ? BIT_NEG : BIT_POS,
                 top_i[TOP_W-1] ? BIT_NEG : BIT_POS};
      end
    end
  end

`ifdef QPSK_DEMOD_SOFT_EN
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      soft_i <= '0;
      soft_q <= '0;
    end else if (dump) begin
      soft_i <= top_i;
      soft_q <= top_q;
    end
  end
`endif

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      ser_state <= IDLE;
    end else begin
      ser_state <= ser_next;
    end
  end

  // Low bit (cos branch) goes out first, matching the modulator's pairing.
  always_comb begin
    ser_next  = ser_state;
    seq_out   = 1'b0;
    seq_valid = 1'b0;
    case (ser_state)
      IDLE: begin
        if (data_valid) ser_next = LOW;
      end
      LOW: begin
        seq_out   = data[0];
        seq_valid = 1'b1;
        ser_next  = HIGH;
      end
      HIGH: begin
        seq_out   = data[1];
        seq_valid = 1'b1;
        ser_next  = IDLE;
      end
      default: ser_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_demod.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_qpsk_demod : directed self-checking bench for qpsk_demod      |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_qpsk_demod;

  logic              clk_1 = 1'b0;
  logic              rst;
  logic signed [7:0] qpsk_in, sine, cos;
  logic              sample_en, sym_start;
  logic [1:0]        data;
  logic              data_valid, seq_out, seq_valid;
`ifdef QPSK_DEMOD_SOFT_EN
  logic signed [11:0] soft_i, soft_q;
`endif

  int   errors = 0;
  int   checks = 0;
  int   dv_cnt = 0;
  int   cyc = 0;
  int   last_dv_cyc = 0;
  int   prev_dv_cyc = 0;
  int   n_dv;
  logic seq_q[$];
  logic [7:0] exp_bits;
  logic signed [7:0] sc [4];
  logic signed [7:0] ss [4];
  logic signed [7:0] sq [4];
  logic [1:0]        sd [4];

  qpsk_demod dut (
    .clk_1      (clk_1),
    .rst        (rst),
    .qpsk_in    (qpsk_in),
    .sine       (sine),
    .cos        (cos),
    .sample_en  (sample_en),
    .sym_start  (sym_start),
    .data       (data),
    .data_valid (data_valid),
    .seq_out    (seq_out),
    .seq_valid  (seq_valid)
`ifdef QPSK_DEMOD_SOFT_EN
    ,
    .soft_i     (soft_i),
    .soft_q     (soft_q)
`endif
  );

  always #5 clk_1 = ~clk_1;

  always @(posedge clk_1) cyc++;

  always @(negedge clk_1) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
    end
    if (seq_valid === 1'b1) seq_q.push_back(seq_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic st, input logic signed [7:0] q,
                      input logic signed [7:0] s, input logic signed [7:0] c);
    sample_en = en;
    sym_start = st;
    qpsk_in   = q;
    sine      = s;
    cos       = c;
    @(posedge clk_1);
    #1;
  endtask

  // alt: odd samples carry -q/4 so the sign of the symbol sum follows q
  task automatic send_sym(input logic first_st, input logic signed [7:0] c,
                          input logic signed [7:0] s, input logic signed [7:0] q,
                          input int n, input logic alt, input logic gap);
    for (int i = 0; i < n; i++) begin
      logic signed [7:0] v;
      v = (alt && (i % 2 == 1)) ? -(q / 8'sd4) : q;
      step(1'b1, first_st && (i == 0), v, s, c);
      if (gap && (i != n - 1)) step(1'b0, 1'b0, v, s, c);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0);
  endtask

  initial begin
    rst = 1'b1;
    sample_en = 1'b0; sym_start = 1'b0;
    qpsk_in = '0; sine = '0; cos = '0;
    repeat (3) @(posedge clk_1);
    #1;
    chk("reset_data", data, 2'b00);
    chk("reset_data_valid", data_valid, 1'b0);
    chk("reset_seq_out", seq_out, 1'b0);
    chk("reset_seq_valid", seq_valid, 1'b0);
    rst = 1'b0;
    idle(2);

    // Constant refs, cos=+100 sine=-100, qpsk_in=+100: decision 01
    send_sym(1'b1, 8'sd100, -8'sd100, 8'sd100, 16, 1'b0, 1'b0);
    chk("basic_dv", data_valid, 1'b1);
    chk("basic_data", data, 2'b01);
`ifdef QPSK_DEMOD_SOFT_EN
    chk("basic_soft_i", {20'b0, soft_i}, 32'h271);
    chk("basic_soft_q", {20'b0, soft_q}, 32'hD8F);
`endif
    step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0);
    chk("basic_dv_pulse", data_valid, 1'b0);
    chk("basic_seq_v0", seq_valid, 1'b1);
    chk("basic_seq_b0", seq_out, 1'b1);
    step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0);
    chk("basic_seq_v1", seq_valid, 1'b1);
    chk("basic_seq_b1", seq_out, 1'b0);
    step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0);
    chk("basic_seq_v2", seq_valid, 1'b0);
    chk("basic_data_hold", data, 2'b01);

    // Async reset mid-symbol at cnt=7
    send_sym(1'b1, 8'sd100, -8'sd100, 8'sd100, 7, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_data", data, 2'b00);
    chk("rst_async_dv", data_valid, 1'b0);
    chk("rst_async_seq_v", seq_valid, 1'b0);
    #2 rst = 1'b0;
    n_dv = dv_cnt;
    send_sym(1'b0, 8'sd100, -8'sd100, 8'sd100, 20, 1'b0, 1'b0);
    idle(2);
    chk("seek_no_dv", dv_cnt, n_dv);
    chk("seek_data", data, 2'b00);

    // All-zero input decides 11
    send_sym(1'b1, 8'sd100, -8'sd100, 8'sd0, 16, 1'b0, 1'b0);
    chk("zero_dv", data_valid, 1'b1);
    chk("zero_data", data, 2'b11);
`ifdef QPSK_DEMOD_SOFT_EN
    chk("zero_soft_i", {20'b0, soft_i}, 32'h0);
    chk("zero_soft_q", {20'b0, soft_q}, 32'h0);
`endif
    idle(4);

    // Free-running symbol sequence 00, 11, 10, 01
    seq_q.delete();
    n_dv = dv_cnt;
    sc = '{8'sd50, 8'sd50, 8'sd50, 8'sd50};
    ss = '{8'sd80, 8'sd80, -8'sd80, -8'sd80};
    sq = '{-8'sd40, 8'sd40, -8'sd40, 8'sd40};
    sd = '{2'b00, 2'b11, 2'b10, 2'b01};
    for (int k = 0; k < 4; k++) begin
      send_sym(k == 0, sc[k], ss[k], sq[k], 16, 1'b1, 1'b0);
      chk($sformatf("seq%0d_dv", k), data_valid, 1'b1);
      chk($sformatf("seq%0d_data", k), data, sd[k]);
    end
    idle(4);
    chk("seq_dv_count", dv_cnt - n_dv, 4);
    chk("seq_bit_count", seq_q.size(), 8);
    exp_bits = 8'b0110_1100;  // bit i = i-th serial bit
    for (int k = 0; k < 8; k++) begin
      if (k < seq_q.size()) chk($sformatf("seq_bit%0d", k), seq_q[k], exp_bits[k]);
    end

    // Resync at cnt=9: aborted symbol (11) never dumps
    send_sym(1'b1, 8'sd50, 8'sd80, 8'sd40, 9, 1'b1, 1'b0);
    n_dv = dv_cnt;
    send_sym(1'b1, 8'sd50, 8'sd80, -8'sd40, 15, 1'b1, 1'b0);
    chk("resync9_no_dv", dv_cnt, n_dv);
    chk("resync9_dv_low", data_valid, 1'b0);
    step(1'b1, 1'b0, -8'sd40, 8'sd80, 8'sd50);
    chk("resync9_dv", data_valid, 1'b1);
    chk("resync9_data", data, 2'b00);

    // sym_start exactly at cnt=SPS-1 wins over the dump
    send_sym(1'b0, 8'sd50, -8'sd80, 8'sd40, 15, 1'b1, 1'b0);
    n_dv = dv_cnt;
    step(1'b1, 1'b1, 8'sd40, 8'sd80, 8'sd50);
    chk("resync15_no_dv", data_valid, 1'b0);
    chk("resync15_data", data, 2'b00);
    send_sym(1'b0, 8'sd50, 8'sd80, 8'sd40, 15, 1'b1, 1'b0);
    chk("resync15_dv", data_valid, 1'b1);
    chk("resync15_data_new", data, 2'b11);
    chk("resync15_dv_count", dv_cnt, n_dv);
    idle(4);

    // sample_en every other cycle: same decisions, 32-clock dv spacing
    send_sym(1'b1, 8'sd50, -8'sd80, 8'sd40, 16, 1'b1, 1'b1);
    chk("gap0_dv", data_valid, 1'b1);
    chk("gap0_data", data, 2'b01);
    step(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0);
    send_sym(1'b0, 8'sd50, 8'sd80, -8'sd40, 16, 1'b1, 1'b1);
    chk("gap1_dv", data_valid, 1'b1);
    chk("gap1_data", data, 2'b00);
    idle(2);
    chk("gap_spacing", last_dv_cyc - prev_dv_cyc, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qpsk_demod.md
# qpsk_demod

Coherent QPSK demodulator that consumes the signed 8-bit QPSK waveform produced by the modulator stage and recovers the transmitted 2-bit symbols and the original serial bit stream. It correlates each input sample against the same local `sine`/`cos` references used by the modulator, integrates over one symbol (integrate-and-dump), and makes a sign decision per branch. Recovered dibits are then re-serialized low bit first, matching the modulator's pairing order. The block sits directly downstream of the modulator in the loopback/receive path.

## Interface
- `SPS`, 16: samples per symbol; power of two, ≥4.
- `ACC_W`, 16+log2(SPS): accumulator width per branch (20 at default).
- `clk_1` input 1: sole clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `qpsk_in` input signed 8: received QPSK sample.
- `sine` input signed 8: local sine reference, phase-aligned with the modulator's.
- `cos` input signed 8: local cosine reference.
- `sample_en` input 1: qualifies `qpsk_in`/`sine`/`cos` this cycle.
- `sym_start` input 1: marks the first sample of a symbol; only sampled when `sample_en`=1.
- `data` output 2: last decided dibit; `data[0]` is the cos branch, `data[1]` is the sine branch.
- `data_valid` output 1: one-cycle pulse when `data` updates.
- `seq_out` output 1: re-serialized bit stream.
- `seq_valid` output 1: qualifies `seq_out`.
- `soft_i`, `soft_q` output signed 12 (only with `QPSK_DEMOD_SOFT_EN`): top 12 bits of the dumped accumulators.

## Operation
- Products: `qpsk_in*cos` and `qpsk_in*sine`, signed 16-bit, sign-extended to ACC_W. Overflow is impossible at ACC_W: |product| ≤ 16384, and 16384·SPS < 2^(ACC_W-1).
- Receiver FSM:
  - SEEK (reset state): samples are ignored until `sample_en`&`sym_start`. That sample loads acc = product, sets cnt=1, and the FSM goes to TRACK.
  - TRACK, `sample_en`, no `sym_start`, cnt<SPS-1: acc += product, cnt++.
  - TRACK, `sample_en`, cnt==SPS-1: dump. `data[0]` = (accI+prodI ≥ 0); `data[1]` = (accQ+prodQ ≥ 0). `data_valid` pulses, acc is cleared, cnt=0.
  - TRACK, `sample_en`&`sym_start` at any cnt, including cnt==SPS-1: resync. The partial symbol is discarded with no `data_valid`; acc = product, cnt=1. `sym_start` wins over dump.
  - cnt==0 in TRACK without `sym_start`: normal first sample of the next symbol (free-running symbol timing).
- Bit mapping is the inverse of the modulator: 11 → +cos+sine, 00 → −cos−sine, 01 → +cos−sine, 10 → −cos+sine. A zero correlation decides 1.
- Serializer FSM, states IDLE/LOW/HIGH:
  - `data_valid` in IDLE → LOW.
  - LOW drives `seq_out`=`data[0]` with `seq_valid`=1, then → HIGH.
  - HIGH drives `seq_out`=`data[1]` with `seq_valid`=1, then → IDLE.
  - SPS≥4 guarantees the serializer is IDLE whenever `data_valid` arrives.
- Reset mid-symbol: all state is cleared, the FSM returns to SEEK, and the partial symbol is lost.

## Timing
- Reset values: `data`=00, `data_valid`=0, `seq_out`=0, `seq_valid`=0, `soft_i`/`soft_q`=0, cnt=0, accs=0. FSMs reset to SEEK/IDLE.
- Dump sample at edge N: `data` and `data_valid` are registered at edge N and visible in cycle N+1.
- `seq_out` low bit is valid in cycle N+2; high bit in cycle N+3.
- `data` holds between dumps. `sample_en`=0 cycles freeze cnt and acc.
- Sustained throughput: one dibit per SPS enabled samples.

## Configuration
- `QPSK_DEMOD_SOFT_EN` defined: `soft_i`/`soft_q` ports exist and are registered with `data` at each dump, taking bits [ACC_W-1:ACC_W-12] of the dumped sums.
- `QPSK_DEMOD_SOFT_EN` undefined: the ports and their registers are absent; hard-decision behaviour is identical.

## Structure
- Package `qpsk_pkg`: SPS default, sample/product widths, receiver state enum (SEEK, TRACK), serializer state enum (IDLE, LOW, HIGH), bit-mapping constants.
- Sub-module `qpsk_correlator`: one signed multiply-accumulate with load/accumulate/clear controls and a dump-sum output. It is instantiated twice, once for I (cos) and once for Q (sine).

## Test plan
- Reset asserted mid-TRACK with cnt=7: all outputs go to 0 immediately, FSM is SEEK; samples without `sym_start` produce no `data_valid`.
- cos=+100, sine=−100 constant, qpsk_in=+100, 16 enabled samples starting with `sym_start`: accI=+160000, accQ=−160000 → `data`=01, single `data_valid`. Then `seq_out` 1 followed by 0 on consecutive `seq_valid` cycles.
- Loopback with the modulator and a 16-entry sine/cos table, symbols 00, 11, 10, 01: `data` sequence 00, 11, 10, 01. `seq_out` reproduces the input bit stream with latency SPS+2 enabled cycles.
- `sym_start` reasserted at cnt=9: no `data_valid` for the aborted symbol; the next dump occurs 16 samples after the resync sample.
- `sample_en` toggled every other cycle: decisions are identical to the continuous case, and `data_valid` spacing is 32 clocks.
- qpsk_in=0 for a full symbol: `data`=11 (zero decides 1). With `QPSK_DEMOD_SOFT_EN`, `soft_i`=`soft_q`=0.
